opl_timer_bank: RTL and testbench
=================================

// Module: opl_timer_bank
// PURPOSE
//   Parametrised bank of OPL-style interval timers sharing one base prescaler. Generalises the single
//   timer to NUM_TIMERS channels with per-channel prescale, sticky status flags, per-channel IRQ masks
//   and a combined interrupt. Sits beside the register file: start/mask/init come from the timer-control
//   registers; flag/irq feed the status register read path.
// PARAMETERS
//   NUM_TIMERS   2      number of timer channels
//   TIMER_WIDTH  8      counter width per channel (overflow at 2**TIMER_WIDTH-1)
//   BASE_TICK    2880   clk cycles per base tick (>=1), e.g. 80 us at the system clock
//   PRESCALE     {8'd4,8'd1}  packed NUM_TIMERS x 8 bits, base ticks per channel tick (each >=1); ch0 = LSBs
// PORTS
//   clk        in   1                    system clock
//   reset      in   1                    asynchronous, active-high reset
//   init       in   NUM_TIMERS*TIMER_WIDTH  per-channel reload value, ch0 = LSBs
//   start      in   NUM_TIMERS           level: channel runs while high
//   mask       in   NUM_TIMERS           1 = overflow does not set flag
//   irq_reset  in   1                    one-cycle pulse: clear all flags
//   overflow   out  NUM_TIMERS           one-cycle pulse per channel overflow (unmasked)
//   flag       out  NUM_TIMERS           sticky per-channel status flag
//   irq        out  1                    OR of flag
// BEHAVIOUR
//   Reset: base counter, sub-prescalers, counters, start history, overflow, flag all 0; irq 0.
//   Base prescaler: free-running 0..BASE_TICK-1 regardless of start; base_tick = (cnt==BASE_TICK-1).
//   Per channel i:
//   - start edge = start[i] & ~start_q[i] (start_q registered). On edge: counter<=init[i], sub<=0.
//   - Sub-prescaler runs only while start[i] and no edge: on base_tick, sub wraps at PRESCALE[i]-1;
//     ch_tick = base_tick & (sub==PRESCALE[i]-1).
//   - On ch_tick: counter==2**TIMER_WIDTH-1 -> counter<=init[i], overflow[i]<=1 next cycle only;
//     else counter<=counter+1. Unsigned, width TIMER_WIDTH, no other wrap.
//   - start[i] low: counter and sub hold; overflow 0. Re-raise reloads init and clears sub.
//   - init change while running takes effect at next reload or start edge only.
//   - init==max: overflow on every ch_tick. Edge and ch_tick in same cycle: edge wins, no overflow.
//   - Steady period (2**TIMER_WIDTH-init)*PRESCALE[i]*BASE_TICK clk; first period short by base phase
//     (up to BASE_TICK-1 clk).
//   Flags: flag[i] set on the same edge overflow[i] rises, only if mask[i]==0 at that cycle. Mask does
//     not clear an existing flag. irq_reset clears all flags; overflow in the same cycle wins for that
//     channel (flag ends 1). irq = |flag, combinational from flag regs, so irq rises with flag.
//   Async reset mid-operation: all state cleared immediately; after release, channels with start high
//     see an edge (start_q=0) and reload init.
// STRUCTURE
//   opl.vh: CLOG2 macro, REG_TIMER_WIDTH default, status bit positions for IRQ/flags.
//   Sub-module opl_timer_channel (start edge detect, sub-prescaler, counter, flag), one per channel via
//   generate; top holds base prescaler and irq OR. Est. 150-250 lines total.
// TESTING (BASE_TICK=4, PRESCALE={8'd4,8'd1}, TIMER_WIDTH=8)
//   1 Assert reset mid-count with start=2'b11 -> overflow=0, flag=0, irq=0 same cycle; reload after release.
//   2 ch0 init=8'hFE, start[0]=1 -> overflow[0] pulses 1 clk every 8 clk; flag[0]=1, irq=1 after first.
//   3 ch0 as 2 with mask[0]=1 -> overflow[0] still pulses every 8 clk; flag[0]=0, irq=0.
//   4 flag[0]=1, irq_reset coincident with overflow[0] -> flag[0] stays 1; irq_reset alone -> flag 0, irq 0.
//   5 ch0 init=8'hF0, drop start after 5 ch_ticks, hold 40 clk, re-raise -> no overflow while low;
//     next overflow after 16 ch_ticks from re-raise.
//   6 ch1 init=8'hFF, start[1]=1 -> overflow[1] every 16 clk; change init to 8'hFE mid-run -> period 32
//     from next reload.

Source files
------------

// File: rtl/opl_timer_bank_pkg.sv
// Shared constants and helpers for the OPL timer bank: prescaler field width,
// status-register bit positions and a width helper for the base prescaler.
package opl_timer_bank_pkg;

    localparam int PRESCALE_W        = 8;
    localparam int REG_TIMER_WIDTH   = 8;
    localparam int STAT_IRQ_BIT      = 7;
    localparam int STAT_FLAG_LSB     = 5;

    // Bits needed to hold 0..v-1, never less than one.
    function automatic int clog2_min1(input int v);
        int w;
        w = 1;
        while ((1 << w) < v) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/opl_timer_channel.sv
// One OPL interval timer: start edge detect, sub-prescaler, up-counter with
// reload, one-cycle overflow pulse and sticky maskable status flag.
module opl_timer_channel
    import opl_timer_bank_pkg::*;
#(
    parameter int                      TIMER_WIDTH = 8,
    parameter logic [PRESCALE_W-1:0]   PRESCALE    = 8'd1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   base_tick,
    input  logic [TIMER_WIDTH-1:0] init,
    input  logic                   start,
    input  logic                   mask,
    input  logic                   irq_reset,
    output logic                   overflow,
    output logic                   flag
);

    logic                   start_q_r;
    logic [PRESCALE_W-1:0]  sub_r;
    logic [TIMER_WIDTH-1:0] cnt_r;
    logic                   overflow_r;
    logic                   flag_r;

    logic                   start_edge_s;
    logic                   sub_wrap_s;
    logic                   ch_tick_s;
    logic                   cnt_max_s;
    logic                   ov_set_s;

    // Tick and overflow decode; a start edge suppresses the tick in that cycle.
    always_comb begin
        start_edge_s = start & ~start_q_r;
        sub_wrap_s   = (sub_r == (PRESCALE - 8'd1));
        ch_tick_s    = start & start_q_r & base_tick & sub_wrap_s;
        cnt_max_s    = (cnt_r == {TIMER_WIDTH{1'b1}});
        ov_set_s     = ch_tick_s & cnt_max_s;
    end

    // Counter, sub-prescaler, overflow pulse and sticky flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_q_r  <= 1'b0;
            sub_r      <= '0;
            cnt_r      <= '0;
            overflow_r <= 1'b0;
            flag_r     <= 1'b0;
        end else begin
            start_q_r  <= start;
            overflow_r <= ov_set_s;
            if (start_edge_s) begin
                cnt_r <= init;
                sub_r <= '0;
            end else if (start && base_tick) begin
                sub_r <= sub_wrap_s ? '0 : (sub_r + 8'd1);
                if (sub_wrap_s) begin
                    cnt_r <= cnt_max_s ? init : (cnt_r + TIMER_WIDTH'(1));
                end else begin
                    cnt_r <= cnt_r;
                end
            end else begin
                sub_r <= sub_r;
                cnt_r <= cnt_r;
            end
            // A new overflow beats a simultaneous clear request.
            if (ov_set_s && !mask) begin
                flag_r <= 1'b1;
            end else if (irq_reset) begin
                flag_r <= 1'b0;
            end else begin
                flag_r <= flag_r;
            end
        end
    end

    assign overflow = overflow_r;
    assign flag     = flag_r;

endmodule

// File: rtl/opl_timer_bank.sv
// Bank of OPL-style interval timers sharing one free-running base prescaler,
// with a combined interrupt formed from the per-channel sticky flags.
module opl_timer_bank
    import opl_timer_bank_pkg::*;
#(
    parameter int                                NUM_TIMERS  = 2,
    parameter int                                TIMER_WIDTH = 8,
    parameter int                                BASE_TICK   = 2880,
    parameter logic [NUM_TIMERS*PRESCALE_W-1:0]  PRESCALE    = {8'd4, 8'd1}
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_TIMERS*TIMER_WIDTH-1:0] init,
    input  logic [NUM_TIMERS-1:0]             start,
    input  logic [NUM_TIMERS-1:0]             mask,
    input  logic                              irq_reset,
    output logic [NUM_TIMERS-1:0]             overflow,
    output logic [NUM_TIMERS-1:0]             flag,
    output logic                              irq
);

    localparam int BASE_W = clog2_min1(BASE_TICK);
    localparam logic [BASE_W-1:0] BASE_LAST = BASE_W'(BASE_TICK - 1);

    logic [BASE_W-1:0] base_cnt_r;
    logic              base_tick_s;

    assign base_tick_s = (base_cnt_r == BASE_LAST);

    // Base prescaler runs continuously, independent of any channel start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base_cnt_r <= '0;
        end else if (base_tick_s) begin
            base_cnt_r <= '0;
        end else begin
            base_cnt_r <= base_cnt_r + BASE_W'(1);
        end
    end

    for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_ch
        opl_timer_channel #(
            .TIMER_WIDTH (TIMER_WIDTH),
            .PRESCALE    (PRESCALE[i*PRESCALE_W +: PRESCALE_W])
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .base_tick (base_tick_s),
            .init      (init[i*TIMER_WIDTH +: TIMER_WIDTH]),
            .start     (start[i]),
            .mask      (mask[i]),
            .irq_reset (irq_reset),
            .overflow  (overflow[i]),
            .flag      (flag[i])
        );
    end

    assign irq = |flag;

endmodule

// File: tb/tb_opl_timer_bank.sv
// Self-checking bench for opl_timer_bank: directed scenarios with literal
// expectations plus randomized stimulus against a behavioural timer model.
module tb_opl_timer_bank;

    localparam int BT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] init = 16'h0000;
    logic [1:0]  start = 2'b00;
    logic [1:0]  mask = 2'b00;
    logic        irq_reset = 1'b0;
    logic [1:0]  overflow;
    logic [1:0]  flag;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    opl_timer_bank #(
        .NUM_TIMERS  (2),
        .TIMER_WIDTH (8),
        .BASE_TICK   (BT),
        .PRESCALE    ({8'd4, 8'd1})
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .init      (init),
        .start     (start),
        .mask      (mask),
        .irq_reset (irq_reset),
        .overflow  (overflow),
        .flag      (flag),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural model: each channel counts base ticks seen while running and
    // ch_ticks since the last reload; overflow when init + ticks reaches 256.
    logic [1:0] m_ov, m_flag, m_prev;
    int         m_cyc;
    int         m_pos [2];
    int         m_bt  [2];
    int         m_init[2];
    logic [15:0] ps_tab = {8'd4, 8'd1};

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) begin
                m_cyc = 0;
                m_ov = 2'b00; m_flag = 2'b00; m_prev = 2'b00;
                for (int c = 0; c < 2; c++) begin
                    m_pos[c] = 0; m_bt[c] = 0; m_init[c] = 0;
                end
            end else begin
                bit bt;
                bt = ((m_cyc % BT) == BT - 1);
                m_cyc++;
                for (int c = 0; c < 2; c++) begin
                    int ps;
                    bit nov;
                    ps = int'(ps_tab[c*8 +: 8]);
                    nov = 1'b0;
                    if (start[c] && !m_prev[c]) begin
                        m_pos[c] = 0; m_bt[c] = 0; m_init[c] = int'(init[c*8 +: 8]);
                    end else if (start[c] && bt) begin
                        m_bt[c]++;
                        if (m_bt[c] % ps == 0) begin
                            m_pos[c]++;
                            if (m_init[c] + m_pos[c] == 256) begin
                                nov = 1'b1;
                                m_pos[c] = 0;
                                m_init[c] = int'(init[c*8 +: 8]);
                            end
                        end
                    end
                    m_ov[c] = nov;
                    if (nov && !mask[c]) m_flag[c] = 1'b1;
                    else if (irq_reset) m_flag[c] = 1'b0;
                    m_prev[c] = start[c];
                end
            end
            #1;
            check("model_overflow", {30'd0, overflow}, {30'd0, m_ov});
            check("model_flag",     {30'd0, flag},     {30'd0, m_flag});
            check("model_irq",      {31'd0, irq},      {31'd0, |m_flag});
        end
    end

    task automatic wait_ov(input int ch, input int budget, output int at);
        at = -1;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk);
            #1;
            if (overflow[ch]) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) check("wait_ov_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1, t2, t3, t4, rel, e, n_low;

        repeat (3) @(negedge clk);
        check("reset_overflow", {30'd0, overflow}, 32'd0);
        check("reset_flag",     {30'd0, flag},     32'd0);
        check("reset_irq",      {31'd0, irq},      32'd0);
        reset = 1'b0;

        // 1: reset mid-count with both channels running
        init = 16'hFF_FE;
        start = 2'b11;
        repeat (30) @(negedge clk);
        check("t1_flag_before", {30'd0, flag}, 32'd3);
        reset = 1'b1;
        #1;
        check("t1_async_overflow", {30'd0, overflow}, 32'd0);
        check("t1_async_flag",     {30'd0, flag},     32'd0);
        check("t1_async_irq",      {31'd0, irq},      32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        rel = cyc;
        wait_ov(0, 40, t1);
        check("t1_reload_latency", t1 - rel, 32'd8);
        @(negedge clk);
        start = 2'b00;
        irq_reset = 1'b1;
        @(negedge clk);
        irq_reset = 1'b0;
        repeat (3) @(negedge clk);

        // 2: ch0 init FE, period 8
        init[7:0] = 8'hFE;
        start[0] = 1'b1;
        wait_ov(0, 40, t1);
        wait_ov(0, 40, t2);
        check("t2_period", t2 - t1, 32'd8);
        check("t2_flag0", {31'd0, flag[0]}, 32'd1);
        check("t2_irq",   {31'd0, irq},     32'd1);

        // 4: clear coincident with overflow keeps flag, clear alone drops it
        repeat (7) @(posedge clk);
        @(negedge clk);
        irq_reset = 1'b1;
        @(posedge clk);
        #1;
        check("t4_coinc_overflow", {31'd0, overflow[0]}, 32'd1);
        check("t4_coinc_flag",     {31'd0, flag[0]},     32'd1);
        @(negedge clk);
        irq_reset = 1'b0;
        @(negedge clk);
        irq_reset = 1'b1;
        @(negedge clk);
        irq_reset = 1'b0;
        check("t4_clear_flag", {31'd0, flag[0]}, 32'd0);
        check("t4_clear_irq",  {31'd0, irq},     32'd0);

        // 3: masked channel still pulses but never flags
        start[0] = 1'b0;
        mask[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b1;
        wait_ov(0, 40, t1);
        wait_ov(0, 40, t2);
        check("t3_period", t2 - t1, 32'd8);
        @(negedge clk);
        check("t3_flag0", {31'd0, flag[0]}, 32'd0);
        check("t3_irq",   {31'd0, irq},     32'd0);
        start[0] = 1'b0;
        mask[0] = 1'b0;
        repeat (2) @(negedge clk);

        // 5: pause mid-count, resume reloads init
        init[7:0] = 8'hF0;
        start[0] = 1'b1;
        repeat (20) @(negedge clk);
        start[0] = 1'b0;
        n_low = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (overflow[0]) n_low++;
        end
        check("t5_no_overflow_low", n_low, 32'd0);
        start[0] = 1'b1;
        e = cyc + 1;
        wait_ov(0, 100, t1);
        check("t5_latency_range", {31'd0, (t1 - e >= 61) && (t1 - e <= 64)}, 32'd1);
        @(negedge clk);
        start[0] = 1'b0;

        // 6: ch1 init FF period 16, then FE gives period 32 after next reload
        init[15:8] = 8'hFF;
        start[1] = 1'b1;
        wait_ov(1, 60, t1);
        wait_ov(1, 60, t2);
        check("t6_period16", t2 - t1, 32'd16);
        @(negedge clk);
        init[15:8] = 8'hFE;
        wait_ov(1, 60, t3);
        check("t6_period_keep", t3 - t2, 32'd16);
        wait_ov(1, 80, t4);
        check("t6_period32", t4 - t3, 32'd32);
        @(negedge clk);
        start = 2'b00;

        // Randomized traffic checked every cycle by the model
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            if ($urandom_range(0, 39) == 0) start[$urandom_range(0, 1)] ^= 1'b1;
            if ($urandom_range(0, 29) == 0) mask[$urandom_range(0, 1)] ^= 1'b1;
            if ($urandom_range(0, 19) == 0) init[$urandom_range(0, 1)*8 +: 8] = 8'(8'hF0 + $urandom_range(0, 15));
            irq_reset = ($urandom_range(0, 24) == 0);
            if (k == 2000) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end
        end
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
